hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS core; drives the pipeline-register enables and clears.
//  Detects load-use/Tuse-Tnew data hazards that forwarding cannot cover and stalls F/D.
//  Owns the mult/div busy sequencer and stalls MDU instructions in D until the HI/LO result exists.
//  Applies the exception/interrupt flush from CP0, which overrides any stall.
// PARAMETERS
//  MULT_LAT  5   cycles mult/multu occupies the MDU after issue from E
//  DIV_LAT   10  cycles div/divu occupies the MDU after issue from E
//  CNT_W     4   width of the MDU countdown; must hold DIV_LAT
// PORTS
//  clk         in   1      system clock, all state on posedge
//  reset       in   1      synchronous, active-high
//  D_rs        in   5      rs field of instruction in D
//  D_rt        in   5      rt field of instruction in D
//  D_tuse_rs   in   2      cycles until D needs rs (0..2; 3 = rs unused)
//  D_tuse_rt   in   2      cycles until D needs rt (0..2; 3 = rt unused)
//  D_is_md     in   1      D instr uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
//  E_A3        in   5      destination reg of instruction in E
//  E_tnew      in   2      cycles until E result is forwardable
//  GRFWE_E     in   1      E instruction writes GRF
//  M_A3        in   5      destination reg of instruction in M
//  M_tnew      in   2      cycles until M result is forwardable
//  GRFWE_M     in   1      M instruction writes GRF
//  E_md_start  in   1      E holds mult/multu/div/divu this cycle
//  E_md_div    in   1      qualifies E_md_start: 1 = div/divu, 0 = mult/multu
//  exc_req     in   1      CP0 exception/interrupt taken at M this cycle
//  pc_en       out  1      PC write enable
//  D_en        out  1      F/D register enable
//  D_clr       out  1      F/D register clear
//  E_clr       out  1      D/E register clear (insert bubble)
//  M_clr       out  1      E/M register clear
//  md_busy     out  1      MDU computing (cnt != 0)
//  md_hilo_we  out  1      one-cycle pulse: write MDU result into HI/LO
//  stall_cnt   out  16     saturating count of stalled cycles
// BEHAVIOUR
//  Stall and flush outputs are combinational from the current-cycle inputs and state.
//  Data hazard term (X = rs or rt), qualified by D_X != 0:
//    hz_X = (GRFWE_E && E_A3==D_X && D_tuse_X < E_tnew)
//         | (GRFWE_M && M_A3==D_X && D_tuse_X < M_tnew)
//    With D_tuse_X = 3, hz_X is never asserted.
//  MDU hazard:  md_stall = D_is_md && (md_busy || E_md_start)
//  Stall:       stall = (hz_rs | hz_rt | md_stall) & ~exc_req
//  Output equations:
//    pc_en = ~stall;  D_en = ~stall;  E_clr = stall | exc_req;  D_clr = M_clr = exc_req
//    exc_req takes priority: every stall is dropped and D/E/M are flushed in the same cycle.
//  MDU sequencer (cnt is CNT_W bits, states IDLE when cnt==0, BUSY otherwise):
//    IDLE + E_md_start & ~exc_req  -> cnt <= E_md_div ? DIV_LAT : MULT_LAT
//    E_md_start together with exc_req does not issue; the instruction is flushed.
//    BUSY -> cnt <= cnt-1 every cycle; exc_req does not abort an issued op.
//    E_md_start while BUSY is ignored and does not reload cnt; D-stage interlock makes it unreachable.
//    md_hilo_we = 1 in the cycle cnt==1, i.e. the last BUSY cycle.
//    Result timing: a mult issued at cycle t writes HI/LO at cycle t+MULT_LAT.
//    Next cycle, mfhi in D proceeds.
//  stall_cnt:
//    Increments on every cycle with stall=1; holds at 16'hFFFF (saturates).
//    Does not count exc_req cycles.
//  Reset (sync): cnt=0, stall_cnt=0.
//    During reset: md_busy=0, md_hilo_we=0, pc_en=D_en=1, D_clr=E_clr=M_clr=1 (pipeline flushed).
//    Reset mid-MDU-op: cnt cleared; no md_hilo_we pulse follows.
// TESTING
//  lw $1 in E (E_tnew=2), addu in D reading rs=$1 (tuse=1):
//    -> stall=1 for 1 cycle (pc_en=0, E_clr=1), then M_tnew=1 and stall=0.
//  D_rs=0 matching E_A3=0 with GRFWE_E=1:
//    -> no stall.
//  beq in D (tuse=0) after addu in E (E_tnew=1, same rt):
//    -> one stall cycle.
//  mult issued (E_md_start=1, E_md_div=0), mflo in D next cycle:
//    -> md_busy for 5 cycles; md_hilo_we pulses in the 5th cycle.
//    -> mflo stalled for those 5 cycles, then released.
//  div issued, exc_req=1 three cycles later:
//    -> D_clr=E_clr=M_clr=1 and pc_en=1 that cycle.
//    -> cnt continues; md_hilo_we still pulses in cycle 10.
//  exc_req concurrent with E_md_start, and reset asserted mid-div:
//    -> no issue: cnt stays 0 and no md_hilo_we pulse.
//  2^16+5 forced stall cycles:
//    -> stall_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline sequencing bundle between the MIPS datapath and hazard_ctrl.
// The datapath side (master) presents the D/E/M stage hazard information
// and CP0 flush request; the controller side (slave) returns the pipeline
// register enables/clears and the MDU sequencing status.
interface hazard_ctrl_if;
    // D-stage consumer
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_is_md;
    // E-stage producer
    logic [4:0]  E_A3;
    logic [1:0]  E_tnew;
    logic        GRFWE_E;
    // M-stage producer
    logic [4:0]  M_A3;
    logic [1:0]  M_tnew;
    logic        GRFWE_M;
    // MDU issue and CP0 flush
    logic        E_md_start;
    logic        E_md_div;
    logic        exc_req;
    // controller outputs
    logic        pc_en;
    logic        D_en;
    logic        D_clr;
    logic        E_clr;
    logic        M_clr;
    logic        md_busy;
    logic        md_hilo_we;
    logic [15:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        output E_A3, E_tnew, GRFWE_E,
        output M_A3, M_tnew, GRFWE_M,
        output E_md_start, E_md_div, exc_req,
        input  pc_en, D_en, D_clr, E_clr, M_clr,
        input  md_busy, md_hilo_we, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        input  E_A3, E_tnew, GRFWE_E,
        input  M_A3, M_tnew, GRFWE_M,
        input  E_md_start, E_md_div, exc_req,
        output pc_en, D_en, D_clr, E_clr, M_clr,
        output md_busy, md_hilo_we, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Stalls F/D on Tuse/Tnew data hazards that forwarding cannot cover and on
// MDU instructions that need HI/LO before the multiplier/divider finishes.
// A CP0 exception flush (or reset) overrides every stall.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    md_state_t        md_state;
    logic [15:0]      stall_cnt_q;

    logic hz_rs;
    logic hz_rt;
    logic md_stall;
    logic flush;
    logic stall;

    // A reader of register src needing it in tuse cycles is blocked by a
    // producer whose result appears only after tnew cycles. $0 never blocks,
    // and tuse=3 (operand unused) can never be below any tnew.
    function automatic logic src_blocked(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       we,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && we && (dst == src) && (tuse < tnew);
    endfunction

    // Saturating increment so the stall counter parks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign md_state = (cnt_q == '0) ? MD_IDLE : MD_BUSY;

    assign hz_rs = src_blocked(hz.D_rs, hz.D_tuse_rs, hz.GRFWE_E, hz.E_A3, hz.E_tnew)
                 | src_blocked(hz.D_rs, hz.D_tuse_rs, hz.GRFWE_M, hz.M_A3, hz.M_tnew);
    assign hz_rt = src_blocked(hz.D_rt, hz.D_tuse_rt, hz.GRFWE_E, hz.E_A3, hz.E_tnew)
                 | src_blocked(hz.D_rt, hz.D_tuse_rt, hz.GRFWE_M, hz.M_A3, hz.M_tnew);

    // Reset looks like a flush to the pipeline: everything cleared, nothing stalled.
    assign flush    = hz.exc_req | reset;
    assign md_stall = hz.D_is_md & (hz.md_busy | hz.E_md_start);
    assign stall    = (hz_rs | hz_rt | md_stall) & ~flush;

    assign hz.pc_en      = ~stall;
    assign hz.D_en       = ~stall;
    assign hz.E_clr      = stall | flush;
    assign hz.D_clr      = flush;
    assign hz.M_clr      = flush;
    assign hz.md_busy    = (md_state == MD_BUSY) & ~reset;
    assign hz.md_hilo_we = (cnt_q == CNT_W'(1)) & ~reset;
    assign hz.stall_cnt  = stall_cnt_q;

    // MDU countdown register; reset drops any in-flight op without a write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // MDU next count: issue only from idle and only if the op is not being
    // flushed; once issued the op runs to completion regardless of exc_req.
    always_comb begin
        cnt_d = cnt_q;
        case (md_state)
            MD_IDLE: begin
                if (hz.E_md_start && !hz.exc_req) begin
                    cnt_d = hz.E_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            default: cnt_d = '0;
        endcase
    end

    // Performance counter of stalled cycles, saturating at 16'hFFFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else if (stall) begin
            stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed instruction scenarios with
// literal expectations, plus a cycle-level reference model compared every cycle.
module tb_hazard_ctrl;
    logic clk;
    logic reset;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // ---------------- reference model ----------------
    // Producers indexed 0 = E, 1 = M. A reader is blocked when some producer
    // writes the same nonzero register and its value arrives later than needed.
    function automatic logic reader_blocked(input logic [4:0] r, input logic [1:0] tuse);
        logic [4:0] dst [2];
        logic       we  [2];
        int         tnew[2];
        logic       b;
        dst[0] = bus.E_A3; we[0] = bus.GRFWE_E; tnew[0] = int'(bus.E_tnew);
        dst[1] = bus.M_A3; we[1] = bus.GRFWE_M; tnew[1] = int'(bus.M_tnew);
        b = 1'b0;
        if (r != 5'd0 && tuse != 2'd3) begin
            for (int s = 0; s < 2; s++) begin
                if (we[s] && dst[s] == r && int'(tuse) < tnew[s]) b = 1'b1;
            end
        end
        return b;
    endfunction

    int cyc      = 0;
    int md_issue = -1000;
    int md_lat   = 0;
    int scnt     = 0;

    // Model state is advanced here too; inputs are stable from posedge+1 to
    // the next posedge, so the negedge sees exactly what the next edge samples.
    always @(negedge clk) begin
        logic busy_e, we_e, hz_e, mds_e, st_e, fl_e;
        busy_e = !reset && (cyc > md_issue) && (cyc <= md_issue + md_lat);
        we_e   = !reset && (cyc == md_issue + md_lat);
        hz_e   = reader_blocked(bus.D_rs, bus.D_tuse_rs) || reader_blocked(bus.D_rt, bus.D_tuse_rt);
        mds_e  = bus.D_is_md && (busy_e || bus.E_md_start);
        fl_e   = reset || bus.exc_req;
        st_e   = !fl_e && (hz_e || mds_e);

        check_b("pc_en",      bus.pc_en,      !st_e);
        check_b("D_en",       bus.D_en,       !st_e);
        check_b("E_clr",      bus.E_clr,      st_e || fl_e);
        check_b("D_clr",      bus.D_clr,      fl_e);
        check_b("M_clr",      bus.M_clr,      fl_e);
        check_b("md_busy",    bus.md_busy,    busy_e);
        check_b("md_hilo_we", bus.md_hilo_we, we_e);
        if (!reset) check("stall_cnt", 32'(bus.stall_cnt), 32'(scnt));

        if (reset) begin
            scnt     = 0;
            md_issue = -1000;
        end else begin
            if (st_e && scnt < 65535) scnt++;
            if (!busy_e && bus.E_md_start && !bus.exc_req) begin
                md_issue = cyc;
                md_lat   = bus.E_md_div ? 10 : 5;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        bus.D_rs = 5'd0;  bus.D_rt = 5'd0;
        bus.D_tuse_rs = 2'd3; bus.D_tuse_rt = 2'd3;
        bus.D_is_md = 1'b0;
        bus.E_A3 = 5'd0;  bus.E_tnew = 2'd0; bus.GRFWE_E = 1'b0;
        bus.M_A3 = 5'd0;  bus.M_tnew = 2'd0; bus.GRFWE_M = 1'b0;
        bus.E_md_start = 1'b0; bus.E_md_div = 1'b0; bus.exc_req = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        settle();
        check_b("rst pc_en", bus.pc_en, 1'b1);
        check_b("rst M_clr", bus.M_clr, 1'b1);
        check_b("rst md_busy", bus.md_busy, 1'b0);
        step();
        step();

        reset = 1'b0;
        settle();
        check("post-rst stall_cnt", 32'(bus.stall_cnt), 0);
        check_b("post-rst E_clr", bus.E_clr, 1'b0);
        check_b("post-rst D_clr", bus.D_clr, 1'b0);
        step();

        // lw $1 in E, addu reading $1 in D: one stall, then forwarding from M
        clear_inputs();
        bus.E_A3 = 5'd1; bus.E_tnew = 2'd2; bus.GRFWE_E = 1'b1;
        bus.D_rs = 5'd1; bus.D_tuse_rs = 2'd1;
        settle();
        check_b("lw-use pc_en", bus.pc_en, 1'b0);
        check_b("lw-use E_clr", bus.E_clr, 1'b1);
        step();
        clear_inputs();
        bus.M_A3 = 5'd1; bus.M_tnew = 2'd1; bus.GRFWE_M = 1'b1;
        bus.D_rs = 5'd1; bus.D_tuse_rs = 2'd1;
        settle();
        check_b("lw-use release pc_en", bus.pc_en, 1'b1);
        step();
        clear_inputs();
        settle();
        check("lw-use stall_cnt", 32'(bus.stall_cnt), 1);

        // $0 never hazards
        bus.D_rs = 5'd0; bus.D_tuse_rs = 2'd0;
        bus.E_A3 = 5'd0; bus.E_tnew = 2'd2; bus.GRFWE_E = 1'b1;
        settle();
        check_b("zero-reg pc_en", bus.pc_en, 1'b1);
        step();

        // tuse=3 means operand unused
        clear_inputs();
        bus.D_rt = 5'd7; bus.D_tuse_rt = 2'd3;
        bus.E_A3 = 5'd7; bus.E_tnew = 2'd3; bus.GRFWE_E = 1'b1;
        settle();
        check_b("unused-op pc_en", bus.pc_en, 1'b1);
        step();

        // producer not writing GRF
        clear_inputs();
        bus.D_rs = 5'd2; bus.D_tuse_rs = 2'd0;
        bus.E_A3 = 5'd2; bus.E_tnew = 2'd2; bus.GRFWE_E = 1'b0;
        settle();
        check_b("no-we pc_en", bus.pc_en, 1'b1);
        step();

        // beq (tuse 0) after addu in E on rt
        clear_inputs();
        bus.D_rt = 5'd5; bus.D_tuse_rt = 2'd0;
        bus.E_A3 = 5'd5; bus.E_tnew = 2'd1; bus.GRFWE_E = 1'b1;
        settle();
        check_b("beq pc_en", bus.pc_en, 1'b0);
        step();
        clear_inputs();
        bus.D_rt = 5'd5; bus.D_tuse_rt = 2'd0;
        bus.M_A3 = 5'd5; bus.M_tnew = 2'd0; bus.GRFWE_M = 1'b1;
        settle();
        check_b("beq release pc_en", bus.pc_en, 1'b1);
        step();

        // hazard against M producer still in flight
        clear_inputs();
        bus.D_rs = 5'd9; bus.D_tuse_rs = 2'd0;
        bus.M_A3 = 5'd9; bus.M_tnew = 2'd1; bus.GRFWE_M = 1'b1;
        settle();
        check_b("M-hz D_en", bus.D_en, 1'b0);
        step();
        clear_inputs();
        settle();
        check("M-hz stall_cnt", 32'(bus.stall_cnt), 3);

        // mult issued, mflo in D afterwards: 5 busy/stalled cycles
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b0;
        settle();
        check_b("mult issue busy", bus.md_busy, 1'b0);
        step();
        clear_inputs();
        bus.D_is_md = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            settle();
            check_b("mult busy",    bus.md_busy,    (k <= 5) ? 1'b1 : 1'b0);
            check_b("mult mflo pc", bus.pc_en,      (k <= 5) ? 1'b0 : 1'b1);
            check_b("mult hilo_we", bus.md_hilo_we, (k == 5) ? 1'b1 : 1'b0);
            step();
        end
        clear_inputs();
        settle();
        check("mult stall_cnt", 32'(bus.stall_cnt), 8);

        // div issued, exception 3 cycles later; div still completes
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        step();
        clear_inputs();
        for (int k = 1; k <= 11; k++) begin
            bus.exc_req = (k == 3);
            bus.D_is_md = (k == 3);
            settle();
            if (k == 3) begin
                check_b("div exc D_clr", bus.D_clr, 1'b1);
                check_b("div exc E_clr", bus.E_clr, 1'b1);
                check_b("div exc M_clr", bus.M_clr, 1'b1);
                check_b("div exc pc_en", bus.pc_en, 1'b1);
            end
            check_b("div hilo_we", bus.md_hilo_we, (k == 10) ? 1'b1 : 1'b0);
            check_b("div busy",    bus.md_busy,    (k <= 10) ? 1'b1 : 1'b0);
            step();
        end
        clear_inputs();
        settle();
        check("div stall_cnt", 32'(bus.stall_cnt), 8);

        // start together with exception: no issue
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b1; bus.exc_req = 1'b1;
        settle();
        check_b("exc+start E_clr", bus.E_clr, 1'b1);
        step();
        clear_inputs();
        for (int k = 1; k <= 12; k++) begin
            settle();
            check_b("exc+start busy", bus.md_busy, 1'b0);
            check_b("exc+start hilo", bus.md_hilo_we, 1'b0);
            step();
        end

        // reset mid-div: op dropped, no write-back
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        reset = 1'b1;
        settle();
        check_b("rst-mid busy",  bus.md_busy, 1'b0);
        check_b("rst-mid pc_en", bus.pc_en,   1'b1);
        check_b("rst-mid E_clr", bus.E_clr,   1'b1);
        step();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            settle();
            check_b("rst-mid hilo", bus.md_hilo_we, 1'b0);
            check_b("rst-mid busy after", bus.md_busy, 1'b0);
            step();
        end
        check("rst-mid stall_cnt", 32'(bus.stall_cnt), 0);

        // saturation: 2^16+5 forced stall cycles
        bus.E_A3 = 5'd1; bus.E_tnew = 2'd2; bus.GRFWE_E = 1'b1;
        bus.D_rs = 5'd1; bus.D_tuse_rs = 2'd0;
        for (int i = 0; i < 65541; i++) step();
        settle();
        check("sat stall_cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
        check_b("sat pc_en", bus.pc_en, 1'b0);
        bus.exc_req = 1'b1;
        settle();
        check_b("sat exc pc_en", bus.pc_en, 1'b1);
        step();
        clear_inputs();
        settle();
        check("sat hold stall_cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
